mips_multicycle_control: RTL and testbench

Parametrised multi-cycle successor to the single-cycle MIPS control decoder. It sequences each instruction through a Moore-style state machine (fetch, decode, execute, memory, writeback). It also stalls on a memory ready handshake and reports completion and illegal opcodes. It sits between the instruction register's opcode field and the shared-ALU / unified-memory multi-cycle datapath.

---
 rtl/mc_ctrl_pkg.sv | 80 ++++++++
 rtl/mc_ctrl_decode.sv | 85 ++++++++
 rtl/mips_multicycle_control.sv | 106 ++++++++++
 tb/tb_mips_multicycle_control.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit.
// Optional ADDI support is enabled by defining MC_CTRL_ADDI_EN.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12,
    S_TRAP   = 4'd15
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_B     = 2'b00,
    SRCB_FOUR  = 2'b01,
    SRCB_IMM   = 2'b10,
    SRCB_IMMSH = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_e;

  typedef struct packed {
    logic    pc_write;
    logic    branch_eq;
    logic    branch_ne;
    logic    iord;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    mem_to_reg;
    logic    reg_dst;
    logic    reg_write;
    logic    alu_src_a;
    src_b_e  alu_src_b;
    alu_op_e alu_op;
    pc_src_e pc_src;
    logic    instr_done;
  } ctrl_t;

  function automatic logic op_known(input logic [5:0] op);
    logic addi_ok;
`ifdef MC_CTRL_ADDI_EN
    addi_ok = 1'b1;
`else
    addi_ok = 1'b0;
`endif
    return (op == OP_R) || (op == OP_LW) ||
           (op == OP_SW) || (op == OP_BEQ) ||
           (op == OP_BNE) || (op == OP_J) ||
           (addi_ok && (op == OP_ADDI));
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// State-to-control output decoder (Moore, plus mem_ready terms).
// ADDI states decode only when MC_CTRL_ADDI_EN is defined.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  state_e state_i,
  input  logic   mem_ready_i,
  output ctrl_t  ctrl_o
);

  // Per-state control word; everything unlisted stays 0
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_src    = PC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMMSH;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.iord       = 1'b1;
        ctrl_o.instr_done = mem_ready_i;
      end
      S_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.reg_dst    = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BEQ, S_BNE: begin
        ctrl_o.alu_src_a  = 1'b1;
        ctrl_o.alu_src_b  = SRCB_B;
        ctrl_o.alu_op     = ALU_SUB;
        ctrl_o.pc_src     = PC_ALUOUT;
        ctrl_o.branch_eq  = (state_i == S_BEQ);
        ctrl_o.branch_ne  = (state_i == S_BNE);
        ctrl_o.instr_done = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: state register and next-state logic.
// Define MC_CTRL_ADDI_EN to add the ADDIEX/ADDIWB path.
module mips_multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       branch_eq,
  output logic       branch_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       instr_done,
  output logic       illegal_op,
  output logic [3:0] state
);

  state_e state_q, state_d;
  ctrl_t  ctrl;
  logic   known;

  assign known = op_known(opcode);

  // State register, async reset back to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state sequencing; opcode only consulted in DECODE/MEMADR
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (!known) begin
          state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
        end else begin
          unique case (1'b1)
            (opcode == OP_LW),
            (opcode == OP_SW):  state_d = S_MEMADR;
            (opcode == OP_R):   state_d = S_EXEC;
            (opcode == OP_BEQ): state_d = S_BEQ;
            (opcode == OP_BNE): state_d = S_BNE;
            (opcode == OP_J):   state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
            (opcode == OP_ADDI): state_d = S_ADDIEX;
`endif
            default: state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
`endif
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  mc_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  // Strobes are killed while reset is low so an abort never writes
  assign pc_write   = ctrl.pc_write   & rst_n;
  assign branch_eq  = ctrl.branch_eq  & rst_n;
  assign branch_ne  = ctrl.branch_ne  & rst_n;
  assign mem_read   = ctrl.mem_read   & rst_n;
  assign mem_write  = ctrl.mem_write  & rst_n;
  assign ir_write   = ctrl.ir_write   & rst_n;
  assign reg_write  = ctrl.reg_write  & rst_n;
  assign instr_done = ctrl.instr_done & rst_n;
  assign illegal_op = rst_n &
    (((state_q == S_DECODE) && !known) ||
     (state_q == S_TRAP));

  assign iord       = ctrl.iord;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_dst    = ctrl.reg_dst;
  assign alu_src_a  = ctrl.alu_src_a;
  assign alu_src_b  = ctrl.alu_src_b;
  assign alu_op     = ctrl.alu_op;
  assign pc_src     = ctrl.pc_src;
  assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: trapping and non-trapping builds
// driven in lockstep, each cycle compared with an instruction-level model.
module tb_mips_multicycle_control;

  localparam logic [5:0] R_OP   = 6'b000000;
  localparam logic [5:0] LW_OP  = 6'b100011;
  localparam logic [5:0] SW_OP  = 6'b101011;
  localparam logic [5:0] BEQ_OP = 6'b000100;
  localparam logic [5:0] BNE_OP = 6'b000101;
  localparam logic [5:0] J_OP   = 6'b000010;
  localparam logic [5:0] AD_OP  = 6'b001000;

  typedef struct packed {
    logic pc_write, branch_eq, branch_ne, iord;
    logic mem_read, mem_write, ir_write, mem_to_reg;
    logic reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic instr_done, illegal_op;
    logic [3:0] state;
  } ov_t;

  logic clk, rst_n, mem_ready;
  logic [5:0] opcode;
  int checks = 0;
  int errors = 0;

  logic pw1, be1, bn1, io1, mr1, mw1, iw1, mt1;
  logic rd1, rw1, sa1, dn1, il1;
  logic [1:0] sb1, ao1, ps1;
  logic [3:0] st1;
  logic pw0, be0, bn0, io0, mr0, mw0, iw0, mt0;
  logic rd0, rw0, sa0, dn0, il0;
  logic [1:0] sb0, ao0, ps0;
  logic [3:0] st0;
  ov_t g1, g0;

  assign g1 = {pw1, be1, bn1, io1, mr1, mw1, iw1, mt1,
               rd1, rw1, sa1, sb1, ao1, ps1, dn1, il1, st1};
  assign g0 = {pw0, be0, bn0, io0, mr0, mw0, iw0, mt0,
               rd0, rw0, sa0, sb0, ao0, ps0, dn0, il0, st0};

  mips_multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .mem_ready(mem_ready),
    .pc_write(pw1), .branch_eq(be1), .branch_ne(bn1),
    .iord(io1), .mem_read(mr1), .mem_write(mw1),
    .ir_write(iw1), .mem_to_reg(mt1), .reg_dst(rd1),
    .reg_write(rw1), .alu_src_a(sa1), .alu_src_b(sb1),
    .alu_op(ao1), .pc_src(ps1), .instr_done(dn1),
    .illegal_op(il1), .state(st1)
  );

  mips_multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
    .mem_ready(mem_ready),
    .pc_write(pw0), .branch_eq(be0), .branch_ne(bn0),
    .iord(io0), .mem_read(mr0), .mem_write(mw0),
    .ir_write(iw0), .mem_to_reg(mt0), .reg_dst(rd0),
    .reg_write(rw0), .alu_src_a(sa0), .alu_src_b(sb0),
    .alu_op(ao0), .pc_src(ps0), .instr_done(dn0),
    .illegal_op(il0), .state(st0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit legal(input logic [5:0] op);
    bit addi = 1'b0;
`ifdef MC_CTRL_ADDI_EN
    addi = 1'b1;
`endif
    return op == R_OP || op == LW_OP || op == SW_OP ||
           op == BEQ_OP || op == BNE_OP || op == J_OP ||
           (addi && op == AD_OP);
  endfunction

  // Expected output word from the state table
  function automatic ov_t exp_o(input int s, input bit mr,
                                input bit ill, input bit rst);
    ov_t o = '0;
    o.state = 4'(s);
    case (s)
      0:  begin o.mem_read = 1; o.alu_src_b = 2'b01;
                o.ir_write = mr; o.pc_write = mr; end
      1:  begin o.alu_src_b = 2'b11; o.illegal_op = ill; end
      2:  begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      3:  begin o.mem_read = 1; o.iord = 1; end
      4:  begin o.reg_write = 1; o.mem_to_reg = 1;
                o.instr_done = 1; end
      5:  begin o.mem_write = 1; o.iord = 1;
                o.instr_done = mr; end
      6:  begin o.alu_src_a = 1; o.alu_op = 2'b10; end
      7:  begin o.reg_write = 1; o.reg_dst = 1;
                o.instr_done = 1; end
      8, 9: begin o.alu_src_a = 1; o.alu_op = 2'b01;
                o.pc_src = 2'b01; o.instr_done = 1;
                o.branch_eq = (s == 8); o.branch_ne = (s == 9); end
      10: begin o.pc_write = 1; o.pc_src = 2'b10;
                o.instr_done = 1; end
      11: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      12: begin o.reg_write = 1; o.instr_done = 1; end
      15: o.illegal_op = 1;
      default: ;
    endcase
    if (rst) begin
      o.pc_write = 0; o.branch_eq = 0; o.branch_ne = 0;
      o.mem_read = 0; o.mem_write = 0; o.ir_write = 0;
      o.reg_write = 0; o.instr_done = 0; o.illegal_op = 0;
    end
    return o;
  endfunction

  task automatic chk(input string tag, input ov_t got, input ov_t e);
    checks++;
    assert (got === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, e);
    end
  endtask

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  task automatic cyc(input int s1, input int s0, input bit mr,
                     input logic [5:0] op, input bit ill);
    mem_ready = mr;
    opcode = op;
    @(negedge clk);
    chk($sformatf("trap st%0d", s1), g1, exp_o(s1, mr, ill, 0));
    chk($sformatf("notrap st%0d", s0), g0, exp_o(s0, mr, ill, 0));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("reset trap", g1, exp_o(0, mem_ready, 0, 1));
    chk("reset notrap", g0, exp_o(0, mem_ready, 0, 1));
    @(posedge clk);
    #1;
    chk("reset hold", g1, exp_o(0, mem_ready, 0, 1));
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input int fs,
                           input int ms, input bit abort);
    bit ill;
    for (int i = 0; i < fs; i++) cyc(0, 0, 0, rop(), 0);
    cyc(0, 0, 1, rop(), 0);
    ill = !legal(op);
    cyc(1, 1, rb(), op, ill);
    if (ill) begin
      for (int i = 0; i < 3; i++) cyc(15, 0, 0, rop(), 0);
      do_reset();
      return;
    end
    case (op)
      LW_OP: begin
        cyc(2, 2, rb(), op, 0);
        for (int i = 0; i < ms; i++) cyc(3, 3, 0, rop(), 0);
        cyc(3, 3, 1, rop(), 0);
        cyc(4, 4, rb(), rop(), 0);
      end
      SW_OP: begin
        cyc(2, 2, rb(), op, 0);
        for (int i = 0; i < ms; i++) begin
          cyc(5, 5, 0, rop(), 0);
          if (abort) begin
            do_reset();
            return;
          end
        end
        cyc(5, 5, 1, rop(), 0);
      end
      R_OP: begin
        cyc(6, 6, rb(), rop(), 0);
        cyc(7, 7, rb(), rop(), 0);
      end
      BEQ_OP: cyc(8, 8, rb(), rop(), 0);
      BNE_OP: cyc(9, 9, rb(), rop(), 0);
      J_OP:   cyc(10, 10, rb(), rop(), 0);
      AD_OP: begin
        cyc(11, 11, rb(), rop(), 0);
        cyc(12, 12, rb(), rop(), 0);
      end
      default: ;
    endcase
  endtask

  initial begin
    logic [5:0] op;
    int k;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    opcode = 6'd0;
    #2;
    do_reset();
    run_instr(LW_OP, 0, 0, 0);
    run_instr(SW_OP, 0, 2, 0);
    run_instr(BNE_OP, 0, 0, 0);
    run_instr(6'b111111, 1, 0, 0);
    run_instr(SW_OP, 0, 1, 1);
    run_instr(AD_OP, 0, 0, 0);
    run_instr(R_OP, 2, 0, 0);
    run_instr(BEQ_OP, 0, 0, 0);
    run_instr(J_OP, 0, 0, 0);
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 7);
      case (k)
        0: op = R_OP;
        1: op = LW_OP;
        2: op = SW_OP;
        3: op = BEQ_OP;
        4: op = BNE_OP;
        5: op = J_OP;
        6: op = AD_OP;
        default: begin
          op = rop();
          while (legal(op)) op = rop();
        end
      endcase
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2),
                ($urandom_range(0, 7) == 0));
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
